kgp_mc_ctrl: RTL

- Multi-cycle control sequencer for the KGP RISC datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives register, memory and PC write enables, and selects sign- or zero-extension of the 16-bit immediate.
- Sits between the instruction register and the datapath; memory access uses a req/ack handshake guarded by a timeout.

---
 rtl/kgp_mc_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/kgp_mc_ctrl.sv
// Multi-cycle control sequencer for the KGP RISC datapath (fetch/decode/exec/mem/wb).
// Optional retired-instruction counter enabled by defining KGP_MC_PERF_EN.
module kgp_mc_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ext_sel,
    output logic       alu_src_imm,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       busy,
    output logic       error,
    output logic [2:0] state
`ifdef KGP_MC_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [2:0] C_ALUR = 3'd0;
    localparam logic [2:0] C_ALUI = 3'd1;
    localparam logic [2:0] C_LOGI = 3'd2;
    localparam logic [2:0] C_LD   = 3'd3;
    localparam logic [2:0] C_ST   = 3'd4;
    localparam logic [2:0] C_BR   = 3'd5;
    localparam logic [2:0] C_JMP  = 3'd6;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_nx;
    logic [2:0] cls;
    logic [7:0] wait_cnt;
    logic       in_mem;
    logic       timeout_hit;
    logic       imm_phase;
    logic       retire;

    assign in_mem      = (state == S_FETCH) || (state == S_MEM);
    // The ack wins over the timeout when both land in the same cycle.
    assign timeout_hit = in_mem && !mem_ack && (wait_cnt == TO_LAST);
    assign imm_phase   = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH: begin
                if (mem_ack)          state_nx = S_DECODE;
                else if (timeout_hit) state_nx = S_ERROR;
            end
            S_DECODE: begin
                if (opcode == 6'h3f)                              state_nx = S_HALT;
                else if (opcode[5:3] == 3'b000 && opcode[2:0] != 3'd7) state_nx = S_EXEC;
                else                                              state_nx = S_ERROR;
            end
            S_EXEC: begin
                case (cls)
                    C_BR, C_JMP: begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                    C_LD, C_ST: state_nx = S_MEM;
                    default:    state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (cls == C_ST) begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_nx = S_ERROR;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default: state_nx = state;
        endcase
    end

    always_comb begin
        mem_req     = in_mem;
        mem_we      = (state == S_MEM) && (cls == C_ST);
        ir_write    = (state == S_FETCH) && mem_ack;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        ext_sel     = imm_phase && (cls == C_LOGI);
        alu_src_imm = imm_phase && ((cls == C_ALUI) || (cls == C_LOGI) ||
                                    (cls == C_LD) || (cls == C_ST));
        reg_write   = (state == S_WB);
        wb_sel      = (state == S_WB) && (cls == C_LD);
        busy        = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);
        error       = (state == S_ERROR);
        if (state == S_FETCH && mem_ack) begin
            pc_write = 1'b1;
        end else if (state == S_EXEC && cls == C_BR) begin
            pc_write = br_taken;
            pc_src   = 2'd1;
        end else if (state == S_EXEC && cls == C_JMP) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
        end
    end

    // The wait counter restarts whenever the FSM enters or leaves a memory state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cls      <= C_ALUR;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) cls <= opcode[2:0];
            if (in_mem && state_nx == state) wait_cnt <= wait_cnt + 8'd1;
            else                             wait_cnt <= 8'd0;
        end
    end

`ifdef KGP_MC_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired <= 32'd0;
        else if (retire) retired <= retired + 32'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
